lab9_soc_sysid_ext: RTL and testbench

Parametrised Avalon-MM system-identification slave for the lab9 SoC. It exposes a configurable ID word, a build timestamp, a coherent 64-bit free-running uptime counter and a bank of writable scratch registers. Responses use registered one-cycle read latency. It replaces the fixed combinational sysid slave on the Nios II data bus and lets software verify the loaded hardware image and measure elapsed cycles.

---
 rtl/lab9_soc_sysid_ext.sv | 112 +++++++++++
 tb/tb_lab9_soc_sysid_ext.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/lab9_soc_sysid_ext.sv
// lab9_soc_sysid_ext
//   Avalon-MM system-identification slave: ID word, build timestamp,
//   coherent 64-bit free-running uptime counter and byte-writable
//   scratch registers. Reads have a registered one-cycle latency.
//
// Ports
//   clock         : sole clock, all state updates on rising edge
//   reset         : synchronous active-high reset
//   address       : word address (ADDR_W bits)
//   read / write  : single-cycle transfer strobes, never stalled
//   writedata     : 32-bit write data
//   byteenable    : byte lanes for scratch writes
//   readdata      : registered read data, holds while readdatavalid = 0
//   readdatavalid : one-cycle pulse per accepted read
//
// Word map: 0 ID, 1 TIMESTAMP, 2 uptime[31:0] (read latches uptime[63:32]),
//   3 high snapshot, 4..4+NUM_SCRATCH-1 scratch, others read 0.
`timescale 1ns/1ps
module lab9_soc_sysid_ext #(
  parameter logic [31:0] ID_VALUE     = 32'd1428568153,
  parameter logic [31:0] TIMESTAMP    = 32'd0,
  parameter int unsigned ADDR_W       = 3,
  parameter int unsigned NUM_SCRATCH  = 2,
  parameter logic [31:0] SCRATCH_INIT = 32'h0
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [ADDR_W-1:0] address,
  input  logic              read,
  input  logic              write,
  input  logic [31:0]       writedata,
  input  logic [3:0]        byteenable,
  output logic [31:0]       readdata,
  output logic              readdatavalid
);

  localparam int unsigned SCR_BASE = 4;

  logic [63:0] r_uptime;
  logic [31:0] r_snap_hi;
  logic [31:0] r_scratch [NUM_SCRATCH];
  logic [31:0] r_readdata;
  logic        r_readdatavalid;

  logic [31:0] w_addr;
  logic        w_up_sel;
  logic        w_clr;
  logic [31:0] w_rdata;

  assign w_addr   = 32'(address);
  assign w_up_sel = (w_addr == 32'd2);
  assign w_clr    = write && w_up_sel;

  // Read mux sees only pre-edge register values, so a same-cycle write
  // never leaks into the data returned for that read.
  always_comb begin
    w_rdata = '0;
    case (w_addr)
      32'd0:   w_rdata = ID_VALUE;
      32'd1:   w_rdata = TIMESTAMP;
      32'd2:   w_rdata = r_uptime[31:0];
      32'd3:   w_rdata = r_snap_hi;
      default: begin
        for (int unsigned i = 0; i < NUM_SCRATCH; i++) begin
          if (w_addr == SCR_BASE + i) w_rdata = r_scratch[i];
        end
      end
    endcase
  end

  // Clear wins over increment.
  always_ff @(posedge clock) begin
    if (reset)      r_uptime <= '0;
    else if (w_clr) r_uptime <= '0;
    else            r_uptime <= r_uptime + 64'd1;
  end

  // High half captured with the same pre-increment value as the low word
  // returned, giving one coherent 64-bit sample.
  always_ff @(posedge clock) begin
    if (reset)                 r_snap_hi <= '0;
    else if (read && w_up_sel) r_snap_hi <= r_uptime[63:32];
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      for (int unsigned i = 0; i < NUM_SCRATCH; i++) r_scratch[i] <= SCRATCH_INIT;
    end else if (write) begin
      for (int unsigned i = 0; i < NUM_SCRATCH; i++) begin
        if (w_addr == SCR_BASE + i) begin
          for (int unsigned b = 0; b < 4; b++) begin
            if (byteenable[b]) r_scratch[i][8*b +: 8] <= writedata[8*b +: 8];
          end
        end
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_readdata      <= '0;
      r_readdatavalid <= 1'b0;
    end else begin
      r_readdatavalid <= read;
      if (read) r_readdata <= w_rdata;
    end
  end

  assign readdata      = r_readdata;
  assign readdatavalid = r_readdatavalid;

endmodule

// File: tb/tb_lab9_soc_sysid_ext.sv
`timescale 1ns/1ps
module tb_lab9_soc_sysid_ext;

  localparam logic [31:0] ID    = 32'd1428568153;
  localparam logic [31:0] TS    = 32'h5A5A0001;
  localparam logic [31:0] SINIT = 32'h0;
  localparam logic [63:0] FORCE_VAL = 64'h0000_0000_FFFF_FFFF;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [2:0]  address = '0;
  logic        read = 1'b0;
  logic        write = 1'b0;
  logic [31:0] writedata = '0;
  logic [3:0]  byteenable = '0;
  logic [31:0] readdata;
  logic        readdatavalid;

  always #5 clock = ~clock;

  lab9_soc_sysid_ext #(
    .ID_VALUE(ID),
    .TIMESTAMP(TS),
    .ADDR_W(3),
    .NUM_SCRATCH(2),
    .SCRATCH_INIT(SINIT)
  ) dut (
    .clock(clock),
    .reset(reset),
    .address(address),
    .read(read),
    .write(write),
    .writedata(writedata),
    .byteenable(byteenable),
    .readdata(readdata),
    .readdatavalid(readdatavalid)
  );

  // ---------------- behavioural model ----------------
  logic [63:0] m_up;
  logic [31:0] m_snap;
  logic [31:0] m_scr [2];
  logic [31:0] exp_rd = '0;
  logic        exp_rdv = 1'b0;
  bit          m_valid = 1'b0;
  bit          do_force = 1'b0;

  function automatic logic [31:0] mread(input logic [2:0] a);
    case (a)
      3'd0: return ID;
      3'd1: return TS;
      3'd2: return m_up[31:0];
      3'd3: return m_snap;
      3'd4: return m_scr[0];
      3'd5: return m_scr[1];
      default: return 32'h0;
    endcase
  endfunction

  initial forever begin
    @(posedge clock);
    if (do_force) m_up = FORCE_VAL;
    if (reset) begin
      m_up = '0; m_snap = '0; m_scr[0] = SINIT; m_scr[1] = SINIT;
      exp_rd = '0; exp_rdv = 1'b0; m_valid = 1'b1;
    end else begin
      exp_rdv = read;
      if (read) begin
        exp_rd = mread(address);
        if (address == 3'd2) m_snap = m_up[63:32];
      end
      if (write && address == 3'd2) m_up = '0;
      else m_up = m_up + 64'd1;
      if (write && (address == 3'd4 || address == 3'd5)) begin
        int idx;
        idx = int'(address) - 4;
        for (int b = 0; b < 4; b++)
          if (byteenable[b]) m_scr[idx][8*b +: 8] = writedata[8*b +: 8];
      end
    end
  end

  // ---------------- compare process ----------------
  int    n_pass = 0;
  int    n_tot = 0;
  int    lit_seq = 0;
  int    lit_done = 0;
  time   lit_at = 0;
  string lit_name = "";
  logic  lit_rdv = 1'b0;
  logic [31:0] lit_val = '0;

  initial forever begin
    @(negedge clock);
    if (m_valid) begin
      n_tot++;
      if (readdatavalid === exp_rdv) n_pass++;
      else $display("FAIL rdv @%0t: got %b expected %b", $time, readdatavalid, exp_rdv);
      n_tot++;
      if (readdata === exp_rd) n_pass++;
      else $display("FAIL readdata @%0t: got %h expected %h", $time, readdata, exp_rd);
    end
    if (lit_seq != lit_done && $time == lit_at) begin
      lit_done = lit_seq;
      n_tot++;
      if (readdatavalid === lit_rdv && readdata === lit_val) n_pass++;
      else $display("FAIL %s: got rdv=%b data=%h expected rdv=%b data=%h",
                    lit_name, readdatavalid, readdata, lit_rdv, lit_val);
    end
  end

  // ---------------- stimulus ----------------
  task automatic cyc(input bit rd, input bit wr, input logic [2:0] a,
                     input logic [31:0] wd, input logic [3:0] be);
    @(negedge clock);
    reset = 1'b0; do_force = 1'b0;
    read = rd; write = wr; address = a; writedata = wd; byteenable = be;
  endtask

  task automatic rst(input bit rd, input logic [2:0] a);
    @(negedge clock);
    reset = 1'b1; do_force = 1'b0;
    read = rd; write = 1'b0; address = a;
  endtask

  task automatic idle(input int n);
    repeat (n) cyc(1'b0, 1'b0, 3'd0, 32'h0, 4'h0);
  endtask

  // Expectation for the outputs one cycle after the transfer just driven.
  task automatic lit(input string nm, input logic v, input logic [31:0] d);
    lit_name = nm; lit_rdv = v; lit_val = d; lit_at = $time + 10; lit_seq++;
  endtask

  initial begin
    rst(1'b0, 3'd0);
    rst(1'b0, 3'd0);
    lit("reset_state", 1'b0, 32'h0);

    idle(10);                                  // k = 0..9
    cyc(1'b1, 1'b0, 3'd2, 32'h0, 4'h0);        // k = 10
    lit("uptime_k10", 1'b1, 32'd10);
    idle(9);                                   // k = 11..19
    cyc(1'b0, 1'b1, 3'd2, 32'hFFFF_FFFF, 4'h0); // k = 20 clear
    cyc(1'b1, 1'b0, 3'd2, 32'h0, 4'h0);        // k = 21
    lit("uptime_after_clr", 1'b1, 32'd0);

    cyc(1'b1, 1'b0, 3'd0, 32'h0, 4'h0); lit("id_word", 1'b1, ID);
    cyc(1'b1, 1'b0, 3'd1, 32'h0, 4'h0); lit("timestamp", 1'b1, TS);
    cyc(1'b1, 1'b0, 3'd7, 32'h0, 4'h0); lit("unmapped7", 1'b1, 32'h0);

    cyc(1'b0, 1'b1, 3'd4, 32'hDEADBEEF, 4'b1111);
    cyc(1'b0, 1'b1, 3'd4, 32'h00000000, 4'b0101);
    cyc(1'b1, 1'b0, 3'd4, 32'h0, 4'h0); lit("scratch_be", 1'b1, 32'hDE00BE00);

    cyc(1'b0, 1'b1, 3'd5, 32'h11111111, 4'hF);
    cyc(1'b1, 1'b1, 3'd5, 32'h22222222, 4'hF); lit("rw_same_old", 1'b1, 32'h11111111);
    cyc(1'b1, 1'b0, 3'd5, 32'h0, 4'h0); lit("rw_same_new", 1'b1, 32'h22222222);

    // Counter preset to just below the 32-bit carry, read in that cycle.
    @(negedge clock);
    reset = 1'b0; write = 1'b0; read = 1'b1; address = 3'd2;
    force dut.r_uptime = FORCE_VAL;
    do_force = 1'b1;
    lit("wrap_lo", 1'b1, 32'hFFFF_FFFF);
    #1 release dut.r_uptime;
    idle(1);
    cyc(1'b1, 1'b0, 3'd3, 32'h0, 4'h0); lit("wrap_hi_snap", 1'b1, 32'h0);
    idle(1);

    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 39) == 0)
        rst(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)));
      else
        cyc(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
            3'($urandom_range(0, 7)), $urandom, 4'($urandom_range(0, 15)));
    end

    cyc(1'b0, 1'b1, 3'd4, 32'h12345678, 4'hF);
    rst(1'b1, 3'd4); lit("reset_mid_read", 1'b0, 32'h0);
    cyc(1'b1, 1'b0, 3'd4, 32'h0, 4'h0); lit("scratch_reset", 1'b1, SINIT);
    idle(2);
    @(negedge clock);
    #1;
    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
